ram_port_ctrl: RTL and testbench
================================

Name: ram_port_ctrl

Overview:
- Sits directly downstream of the memory access unit: it takes that stage's single-cycle load/store intent and turns it into a timed transaction on the 8-bit data RAM.
- Latches each request, holds RAM control and address stable for a programmable number of wait states, and captures read data.
- Returns a one-cycle response and a stall to the pipeline, so slow RAM never corrupts a load or store.

Parameters:
- ADDR_W, 8, RAM address width in bits.
- DATA_W, 8, RAM data width in bits (matches the 8-bit register/RAM datapath).
- WAIT_STATES, 1, extra RAM access cycles beyond the first; legal range 0..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  1  memory access stage presents a request.
- REQ_RW  input  1  0 = read (load), 1 = write (store); same encoding as the MAU RW output.
- REQ_ADDR  input  ADDR_W  target RAM address.
- REQ_WDATA  input  DATA_W  store data (the R1 value).
- REQ_READY  output  1  controller can accept a request this cycle.
- RSP_VALID  output  1  one-cycle pulse: transaction complete.
- RSP_RDATA  output  DATA_W  captured load data; holds its value between loads.
- STALL  output  1  pipeline must freeze the memory access stage.
- RAM_CE  output  1  RAM chip enable.
- RAM_WE  output  1  RAM write enable (1 = write).
- RAM_ADDR  output  ADDR_W  RAM address.
- RAM_DIN  output  DATA_W  data driven to the RAM.
- RAM_DOUT  input  DATA_W  data returned by the RAM; valid by the last access cycle.

Behaviour:
- States: IDLE, ACCESS, DONE. The FSM is 2 bits; a 4-bit wait counter WCNT runs alongside it.
- Reset (RST = 1 at an edge):
  - State goes to IDLE and WCNT to 0.
  - RAM_CE, RAM_WE, RSP_VALID and STALL go to 0; REQ_READY goes to 1.
  - RAM_ADDR, RAM_DIN and RSP_RDATA go to 0.
  - Reset mid-transaction aborts it with no response, and RAM_CE is low from the next cycle.
- IDLE:
  - REQ_READY = 1.
  - A request is accepted when REQ_VALID = 1 at an edge. At that edge, REQ_ADDR goes to RAM_ADDR, REQ_WDATA goes to RAM_DIN, REQ_RW goes to RAM_WE, RAM_CE is set to 1, WCNT is loaded with WAIT_STATES, and the FSM moves to ACCESS.
  - With no request, the RAM outputs stay quiet: CE = 0, WE = 0.
- ACCESS:
  - REQ_READY = 0. RAM_CE, RAM_WE, RAM_ADDR and RAM_DIN are held constant.
  - While WCNT ≠ 0, WCNT decrements each edge.
  - When WCNT = 0 at an edge:
    - On a read, RAM_DOUT is captured into RSP_RDATA.
    - RAM_CE and RAM_WE are cleared, RSP_VALID is set to 1, and the FSM moves to DONE.
  - ACCESS lasts exactly WAIT_STATES + 1 cycles.
- DONE:
  - RSP_VALID = 1 for exactly this one cycle; the next edge clears it and returns to IDLE.
  - Writes also pulse RSP_VALID (store acknowledge) and leave RSP_RDATA unchanged.
- STALL = 1 whenever the state is not IDLE, or the state is IDLE and REQ_VALID = 1.
  - This means STALL is asserted in the accept cycle as well. The upstream stage holds its request until it sees RSP_VALID.
- REQ_* changes while not in IDLE are ignored, because all request fields were latched at acceptance.
- Timing:
  - Latency: accept edge at cycle 0, ACCESS occupies cycles 1..WAIT_STATES+1, RSP_VALID is high in cycle WAIT_STATES+2.
  - Throughput: one transaction per WAIT_STATES + 3 cycles. No back-to-back acceptance from DONE.
- WAIT_STATES = 0: ACCESS lasts a single cycle, and read data is sampled at the end of that cycle.
- Width rules: all paths pass straight through with no extension or truncation. WCNT is 4 bits wide, and WAIT_STATES > 15 is a static elaboration error.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - the state encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2;
  - RW_READ = 1'b0 and RW_WRITE = 1'b1, shared with the memory access unit.
- No sub-module. The wait counter and the FSM are small enough to stay inline in one module.

Test Plan:
- Reset: hold RST for 2 cycles with REQ_VALID = 1 → RAM_CE = 0, RSP_VALID = 0, REQ_READY = 1 after release, and no transaction is started during reset.
- Read, WAIT_STATES = 1: request RW = 0, ADDR = 8'h3A; RAM model returns 8'hC5 → RAM_CE high for exactly 2 cycles with RAM_ADDR = 8'h3A and RAM_WE = 0; RSP_VALID pulses in cycle 3; RSP_RDATA = 8'hC5.
- Write, WAIT_STATES = 1: request RW = 1, ADDR = 8'h10, WDATA = 8'h7E → RAM_WE and RAM_CE are high for 2 cycles with RAM_DIN = 8'h7E; the RAM model holds 8'h7E at 8'h10; RSP_VALID pulses; RSP_RDATA keeps the prior value 8'hC5.
- Input stability: change REQ_ADDR to 8'hFF during ACCESS → RAM_ADDR stays at the latched 8'h3A for the whole access, and STALL stays high until DONE.
- Reset mid-op: assert RST in the first ACCESS cycle → next cycle RAM_CE = 0 and state is IDLE, no RSP_VALID pulse, and RSP_RDATA = 0.
- WAIT_STATES = 0, back-to-back: read 8'h01 then read 8'h02 with REQ_VALID held → each access has 1 CE cycle and RSP_VALID arrives 2 cycles after acceptance; the second request is accepted 3 cycles after the first.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: state encoding and RW encoding shared with the memory access unit
package cpu_mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    localparam int   WCNT_W   = 4;
endpackage

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: turns single-cycle load/store intent into a wait-stated RAM transaction
module ram_port_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    input  logic              REQ_RW,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              REQ_READY,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              STALL,
    output logic              RAM_CE,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DIN,
    input  logic [DATA_W-1:0] RAM_DOUT
);
    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
            $error("WAIT_STATES must be within 0..15");
        end
    endgenerate
    localparam logic [WCNT_W-1:0] WS = WCNT_W'(WAIT_STATES);
    state_t              state, state_n;
    logic [WCNT_W-1:0]   wcnt, wcnt_n;
    logic                we_q;
    logic                accept, last;
    assign accept    = state == ST_IDLE && REQ_VALID;
    assign last      = state == ST_ACCESS && wcnt == '0;
    assign REQ_READY = state == ST_IDLE;
    assign RSP_VALID = state == ST_DONE;
    assign RAM_CE    = state == ST_ACCESS;
    assign RAM_WE    = RAM_CE && we_q == RW_WRITE;
    // the accept cycle stalls too: the request is not consumed until the response
    assign STALL     = !REQ_READY || REQ_VALID;
    always_comb begin
        state_n = accept ? ST_ACCESS : last ? ST_DONE : state == ST_DONE ? ST_IDLE : state;
        wcnt_n  = accept ? WS : (state == ST_ACCESS && wcnt != '0) ? wcnt - 1'b1 : wcnt;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            we_q      <= RW_READ;
            RAM_ADDR  <= '0;
            RAM_DIN   <= '0;
            RSP_RDATA <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (accept) begin
                RAM_ADDR <= REQ_ADDR;
                RAM_DIN  <= REQ_WDATA;
                we_q     <= REQ_RW;
            end
            if (last && we_q == RW_READ)
                RSP_RDATA <= RAM_DOUT;
        end
    end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: two controllers (WAIT_STATES 1 and 0) on shared stimulus,
// each checked every cycle against a transaction-timing reference model
module tb_ram_port_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst, req_valid, req_rw;
    logic [7:0] req_addr, req_wdata;
    logic       ready [2];
    logic       rsp   [2];
    logic       stall [2];
    logic       ce    [2];
    logic       we    [2];
    logic [7:0] rdata [2];
    logic [7:0] addr  [2];
    logic [7:0] din   [2];
    logic [7:0] dout  [2];
    logic [7:0] ram   [2][256];
    int         ws [2] = '{1, 0};
    bit         m_busy [2];
    int         m_ph   [2];
    bit         m_we   [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_din  [2];
    logic [7:0] m_rd   [2];
    logic [7:0] mref   [2][256];
    int checks = 0;
    int failures = 0;
    ram_port_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) dut1 (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_RW(req_rw),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_READY(ready[0]),
        .RSP_VALID(rsp[0]), .RSP_RDATA(rdata[0]), .STALL(stall[0]),
        .RAM_CE(ce[0]), .RAM_WE(we[0]), .RAM_ADDR(addr[0]), .RAM_DIN(din[0]),
        .RAM_DOUT(dout[0])
    );
    ram_port_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_RW(req_rw),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_READY(ready[1]),
        .RSP_VALID(rsp[1]), .RSP_RDATA(rdata[1]), .STALL(stall[1]),
        .RAM_CE(ce[1]), .RAM_WE(we[1]), .RAM_ADDR(addr[1]), .RAM_DIN(din[1]),
        .RAM_DOUT(dout[1])
    );
    // behavioural RAM devices: combinational read, write on every enabled edge
    assign dout[0] = ram[0][addr[0]];
    assign dout[1] = ram[1][addr[1]];
    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (ce[k] && we[k]) ram[k][addr[k]] <= din[k];
    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s ws=%0d observed=%0h expected=%0h", tag, ws[k], obs, exp);
        end
    endtask
    // phase counts cycles since the idle cycle in which the request was seen
    task automatic advance(input int k, input bit r, input bit v, input bit rw,
                           input logic [7:0] a, input logic [7:0] d);
        if (m_busy[k] && m_ph[k] <= ws[k] + 1 && m_we[k]) mref[k][m_addr[k]] = m_din[k];
        if (r) begin
            m_busy[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_din[k] = 0; m_rd[k] = 0;
        end else if (!m_busy[k]) begin
            if (v) begin
                m_busy[k] = 1; m_ph[k] = 1; m_we[k] = rw; m_addr[k] = a; m_din[k] = d;
            end
        end else if (m_ph[k] == ws[k] + 2) begin
            m_busy[k] = 0;
        end else begin
            if (m_ph[k] == ws[k] + 1 && !m_we[k]) m_rd[k] = mref[k][m_addr[k]];
            m_ph[k]++;
        end
    endtask
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit e_ce;
            e_ce = m_busy[k] && m_ph[k] <= ws[k] + 1;
            chk("ready", k, 8'(ready[k]), 8'(!m_busy[k]));
            chk("rsp_valid", k, 8'(rsp[k]), 8'(m_busy[k] && m_ph[k] == ws[k] + 2));
            chk("stall", k, 8'(stall[k]), 8'(m_busy[k] || req_valid));
            chk("ram_ce", k, 8'(ce[k]), 8'(e_ce));
            chk("ram_we", k, 8'(we[k]), 8'(e_ce && m_we[k]));
            chk("ram_addr", k, addr[k], m_addr[k]);
            chk("ram_din", k, din[k], m_din[k]);
            chk("rsp_rdata", k, rdata[k], m_rd[k]);
        end
    endtask
    task automatic cyc(input bit r, input bit v, input bit rw, input logic [7:0] a, input logic [7:0] d);
        rst = r; req_valid = v; req_rw = rw; req_addr = a; req_wdata = d;
        for (int k = 0; k < 2; k++) advance(k, r, v, rw, a, d);
        @(posedge clk);
        #1;
        check_all();
    endtask
    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            ram[k][a] = d;
            mref[k][a] = d;
        end
    endtask
    initial begin
        rst = 1; req_valid = 0; req_rw = 0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        preload(8'h3A, 8'hC5);
        preload(8'h01, 8'hA1);
        preload(8'h02, 8'h5D);
        // reset held two cycles with a pending request
        cyc(1, 1, 0, 8'h3A, 0);
        chk("rst_ce", 0, 8'(ce[0]), 8'h0);
        cyc(1, 1, 0, 8'h3A, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_ready", 0, 8'(ready[0]), 8'h1);
        chk("rst_rsp", 0, 8'(rsp[0]), 8'h0);
        // read 3A, address input disturbed during the access
        cyc(0, 1, 0, 8'h3A, 0);
        chk("rd_ce1", 0, 8'(ce[0]), 8'h1);
        chk("rd_addr1", 0, addr[0], 8'h3A);
        cyc(0, 1, 0, 8'hFF, 0);
        chk("rd_ce2", 0, 8'(ce[0]), 8'h1);
        chk("rd_addr2", 0, addr[0], 8'h3A);
        chk("rd_stall", 0, 8'(stall[0]), 8'h1);
        cyc(0, 0, 0, 0, 0);
        chk("rd_rsp", 0, 8'(rsp[0]), 8'h1);
        chk("rd_data", 0, rdata[0], 8'hC5);
        chk("rd_ce_off", 0, 8'(ce[0]), 8'h0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // write 7E to 10
        cyc(0, 1, 1, 8'h10, 8'h7E);
        chk("wr_we1", 0, 8'(we[0]), 8'h1);
        chk("wr_din", 0, din[0], 8'h7E);
        cyc(0, 0, 0, 0, 0);
        chk("wr_we2", 0, 8'(we[0]), 8'h1);
        cyc(0, 0, 0, 0, 0);
        chk("wr_rsp", 0, 8'(rsp[0]), 8'h1);
        chk("wr_keep_rdata", 0, rdata[0], 8'hC5);
        chk("wr_ram", 0, ram[0][8'h10], 8'h7E);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // reset in the first access cycle
        cyc(0, 1, 0, 8'h3A, 0);
        cyc(1, 0, 0, 0, 0);
        chk("abort_ce", 0, 8'(ce[0]), 8'h0);
        chk("abort_ready", 0, 8'(ready[0]), 8'h1);
        chk("abort_rdata", 0, rdata[0], 8'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        // zero wait states, back-to-back reads held by the upstream stage
        cyc(0, 1, 0, 8'h01, 0);
        chk("b2b_ce1", 1, 8'(ce[1]), 8'h1);
        chk("b2b_addr1", 1, addr[1], 8'h01);
        cyc(0, 1, 0, 8'h01, 0);
        chk("b2b_rsp1", 1, 8'(rsp[1]), 8'h1);
        chk("b2b_data1", 1, rdata[1], 8'hA1);
        cyc(0, 1, 0, 8'h02, 0);
        chk("b2b_gap_ce", 1, 8'(ce[1]), 8'h0);
        chk("b2b_gap_stall", 1, 8'(stall[1]), 8'h1);
        cyc(0, 1, 0, 8'h02, 0);
        chk("b2b_ce2", 1, 8'(ce[1]), 8'h1);
        chk("b2b_addr2", 1, addr[1], 8'h02);
        cyc(0, 0, 0, 0, 0);
        chk("b2b_rsp2", 1, 8'(rsp[1]), 8'h1);
        chk("b2b_data2", 1, rdata[1], 8'h5D);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        // randomized traffic over a small address window so reads hit earlier writes
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                8'($urandom_range(0, 15)), 8'($urandom));
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
